basic_axi4_burst_mem_slave: RTL and testbench

//  AXI4 (full, burst-capable) memory-mapped slave backed by an internal register-array memory.
//  It is the responder for the AXI4 master agent that issues the INCR write and read bursts in the basicSampler bench.
//  It lets those bursts complete against real storage, and it is the sample store behind basicSampler's S00_AXI port.

---
 rtl/basic_axi4_burst_mem_slave_if.sv | 56 +++++
 rtl/basic_axi4_burst_mem_slave.sv | 225 ++++++++++++++++++++++
 tb/tb_basic_axi4_burst_mem_slave.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/basic_axi4_burst_mem_slave_if.sv
// AXI4 burst slave bus bundle: AW, W, B, AR and R channels.
// Single-ID, so no ID/USER/SIZE signals are carried.
interface basic_axi4_burst_mem_slave_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
   logic [7:0]              S_AXI_AWLEN;
   logic [1:0]              S_AXI_AWBURST;
   logic                    S_AXI_AWVALID;
   logic                    S_AXI_AWREADY;
   logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
   logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                    S_AXI_WLAST;
   logic                    S_AXI_WVALID;
   logic                    S_AXI_WREADY;
   logic [1:0]              S_AXI_BRESP;
   logic                    S_AXI_BVALID;
   logic                    S_AXI_BREADY;
   logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
   logic [7:0]              S_AXI_ARLEN;
   logic [1:0]              S_AXI_ARBURST;
   logic                    S_AXI_ARVALID;
   logic                    S_AXI_ARREADY;
   logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
   logic [1:0]              S_AXI_RRESP;
   logic                    S_AXI_RLAST;
   logic                    S_AXI_RVALID;
   logic                    S_AXI_RREADY;

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
      input  S_AXI_RREADY
   );

   modport master (
      output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
      output S_AXI_RREADY
   );
endinterface

// File: rtl/basic_axi4_burst_mem_slave.sv
// AXI4 INCR/FIXED burst slave over a register-array memory.
// Independent write and read FSMs, one burst each at a time.
module basic_axi4_burst_mem_slave #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int MEM_DEPTH  = 16
) (
   input logic ACLK,
   input logic ARESET,
   basic_axi4_burst_mem_slave_if.slave s_axi
);
   localparam int ADDR_LSB = $clog2(DATA_WIDTH/8);
   localparam int IDX_W    = $clog2(MEM_DEPTH);
   localparam int NB       = DATA_WIDTH/8;
   localparam logic [1:0] FIXED  = 2'b00;
   localparam logic [1:0] INCR   = 2'b01;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   w_state_t w_state, w_next;
   logic [IDX_W-1:0] w_idx, w_idx_d;
   logic [7:0] w_len, w_len_d, w_beat, w_beat_d;
   logic w_incr, w_incr_d, w_ok, w_ok_d, w_err, w_err_d;
   logic awready, awready_d, wready, wready_d, bvalid, bvalid_d;
   logic w_en;

   r_state_t r_state, r_next;
   logic [IDX_W-1:0] r_idx, r_idx_d, r_nidx, a_idx;
   logic [7:0] r_len, r_len_d, r_beat, r_beat_d;
   logic r_incr, r_incr_d, r_ok, r_ok_d, a_ok;
   logic arready, arready_d, rvalid, rvalid_d, rlast, rlast_d;
   logic [1:0] rresp, rresp_d;
   logic [DATA_WIDTH-1:0] rdata, rdata_d;

   // Address bits outside the word index are deliberately ignored.
   logic addr_unused;
   assign addr_unused = ^{s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR};

   assign s_axi.S_AXI_AWREADY = awready;
   assign s_axi.S_AXI_WREADY  = wready;
   assign s_axi.S_AXI_BVALID  = bvalid;
   assign s_axi.S_AXI_BRESP   = (bvalid && (w_err || !w_ok)) ? SLVERR : OKAY;
   assign s_axi.S_AXI_ARREADY = arready;
   assign s_axi.S_AXI_RVALID  = rvalid;
   assign s_axi.S_AXI_RLAST   = rlast;
   assign s_axi.S_AXI_RRESP   = rresp;
   assign s_axi.S_AXI_RDATA   = rdata;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         w_state <= W_IDLE;
         w_idx   <= '0;
         w_len   <= '0;
         w_beat  <= '0;
         w_incr  <= 1'b0;
         w_ok    <= 1'b0;
         w_err   <= 1'b0;
         awready <= 1'b0;
         wready  <= 1'b0;
         bvalid  <= 1'b0;
      end else begin
         w_state <= w_next;
         w_idx   <= w_idx_d;
         w_len   <= w_len_d;
         w_beat  <= w_beat_d;
         w_incr  <= w_incr_d;
         w_ok    <= w_ok_d;
         w_err   <= w_err_d;
         awready <= awready_d;
         wready  <= wready_d;
         bvalid  <= bvalid_d;
      end
   end

   always_comb begin
      w_next    = w_state;
      w_idx_d   = w_idx;
      w_len_d   = w_len;
      w_beat_d  = w_beat;
      w_incr_d  = w_incr;
      w_ok_d    = w_ok;
      w_err_d   = w_err;
      awready_d = awready;
      wready_d  = wready;
      bvalid_d  = bvalid;
      w_en      = 1'b0;
      unique case (w_state)
         W_IDLE: begin
            awready_d = 1'b1;
            if (s_axi.S_AXI_AWVALID && awready) begin
               w_idx_d   = s_axi.S_AXI_AWADDR[ADDR_LSB +: IDX_W];
               w_len_d   = s_axi.S_AXI_AWLEN;
               w_beat_d  = '0;
               w_incr_d  = s_axi.S_AXI_AWBURST == INCR;
               w_ok_d    = s_axi.S_AXI_AWBURST == INCR
                        || s_axi.S_AXI_AWBURST == FIXED;
               w_err_d   = 1'b0;
               awready_d = 1'b0;
               wready_d  = 1'b1;
               w_next    = W_DATA;
            end
         end
         W_DATA: begin
            if (s_axi.S_AXI_WVALID && wready) begin
               w_en     = w_ok;
               w_err_d  = w_err
                        | (s_axi.S_AXI_WLAST != (w_beat == w_len));
               w_beat_d = w_beat + 8'd1;
               if (w_incr)
                  w_idx_d = w_idx + 1'b1;
               // Beat count, not WLAST, closes the burst.
               if (w_beat == w_len) begin
                  wready_d = 1'b0;
                  bvalid_d = 1'b1;
                  w_next   = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (s_axi.S_AXI_BREADY) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               w_next    = W_IDLE;
            end
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (w_en)
         for (int b = 0; b < NB; b++)
            if (s_axi.S_AXI_WSTRB[b])
               mem[w_idx][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state <= R_IDLE;
         r_idx   <= '0;
         r_len   <= '0;
         r_beat  <= '0;
         r_incr  <= 1'b0;
         r_ok    <= 1'b0;
         arready <= 1'b0;
         rvalid  <= 1'b0;
         rlast   <= 1'b0;
         rresp   <= OKAY;
         rdata   <= '0;
      end else begin
         r_state <= r_next;
         r_idx   <= r_idx_d;
         r_len   <= r_len_d;
         r_beat  <= r_beat_d;
         r_incr  <= r_incr_d;
         r_ok    <= r_ok_d;
         arready <= arready_d;
         rvalid  <= rvalid_d;
         rlast   <= rlast_d;
         rresp   <= rresp_d;
         rdata   <= rdata_d;
      end
   end

   assign a_idx  = s_axi.S_AXI_ARADDR[ADDR_LSB +: IDX_W];
   assign a_ok   = s_axi.S_AXI_ARBURST == INCR
                || s_axi.S_AXI_ARBURST == FIXED;
   assign r_nidx = r_incr ? r_idx + 1'b1 : r_idx;

   always_comb begin
      r_next    = r_state;
      r_idx_d   = r_idx;
      r_len_d   = r_len;
      r_beat_d  = r_beat;
      r_incr_d  = r_incr;
      r_ok_d    = r_ok;
      arready_d = arready;
      rvalid_d  = rvalid;
      rlast_d   = rlast;
      rresp_d   = rresp;
      rdata_d   = rdata;
      unique case (r_state)
         R_IDLE: begin
            arready_d = 1'b1;
            if (s_axi.S_AXI_ARVALID && arready) begin
               r_idx_d   = a_idx;
               r_len_d   = s_axi.S_AXI_ARLEN;
               r_beat_d  = '0;
               r_incr_d  = s_axi.S_AXI_ARBURST == INCR;
               r_ok_d    = a_ok;
               arready_d = 1'b0;
               rvalid_d  = 1'b1;
               rlast_d   = s_axi.S_AXI_ARLEN == 8'd0;
               rresp_d   = a_ok ? OKAY : SLVERR;
               rdata_d   = a_ok ? mem[a_idx] : '0;
               r_next    = R_DATA;
            end
         end
         R_DATA: begin
            // Reload on the handshake edge for one beat per cycle.
            if (rvalid && s_axi.S_AXI_RREADY) begin
               if (rlast) begin
                  rvalid_d  = 1'b0;
                  rlast_d   = 1'b0;
                  rresp_d   = OKAY;
                  rdata_d   = '0;
                  arready_d = 1'b1;
                  r_next    = R_IDLE;
               end else begin
                  r_idx_d  = r_nidx;
                  r_beat_d = r_beat + 8'd1;
                  rlast_d  = (r_beat + 8'd1) == r_len;
                  rdata_d  = r_ok ? mem[r_nidx] : '0;
               end
            end
         end
         default: r_next = R_IDLE;
      endcase
   end
endmodule

// File: tb/tb_basic_axi4_burst_mem_slave.sv
// Bench for basic_axi4_burst_mem_slave: vector table plus reset and
// read/write collision sequences, scoreboarded against a memory model.
module tb_basic_axi4_burst_mem_slave;
   localparam logic [1:0] FIXED  = 2'b00;
   localparam logic [1:0] INCR   = 2'b01;
   localparam logic [1:0] WRAP   = 2'b10;
   localparam logic [1:0] RSVD   = 2'b11;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef struct {
      bit         wr;
      logic [7:0] addr;
      logic [7:0] len;
      logic [1:0] burst;
      logic [31:0] base;
      logic [3:0] strb;
      int         early;
      int         bdly;
      bit         tog;
      logic [1:0] resp;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } rexp_t;

   logic ACLK = 1'b0;
   logic ARESET;
   int checks = 0;
   int failures = 0;

   logic [31:0] ref_mem [16];
   rexp_t r_q [$];
   logic [1:0] b_q [$];
   vec_t vecs [16];

   bit r_hold = 0;
   logic [31:0] held_data;
   logic [2:0]  held_ctl;

   basic_axi4_burst_mem_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

   basic_axi4_burst_mem_slave #(
      .DATA_WIDTH(32), .ADDR_WIDTH(8), .MEM_DEPTH(16)
   ) dut (
      .ACLK(ACLK),
      .ARESET(ARESET),
      .s_axi(bus)
   );

   always #5 ACLK = ~ACLK;

   function automatic void chk(input string nm, input logic [63:0] act,
                               input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endfunction

   // Output monitor: pops the scoreboards on each R / B handshake.
   always @(negedge ACLK) begin
      if (ARESET) begin
         r_hold = 0;
      end else begin
         if (bus.S_AXI_RVALID) begin
            if (r_hold) begin
               chk("r_hold_data", bus.S_AXI_RDATA, held_data);
               chk("r_hold_ctl", {bus.S_AXI_RRESP, bus.S_AXI_RLAST}, held_ctl);
            end
            if (bus.S_AXI_RREADY) begin
               r_hold = 0;
               if (r_q.size() == 0) begin
                  chk("r_unexpected", 1, 0);
               end else begin
                  rexp_t e;
                  e = r_q.pop_front();
                  chk("r_data", bus.S_AXI_RDATA, e.data);
                  chk("r_resp_last", {bus.S_AXI_RRESP, bus.S_AXI_RLAST},
                      {e.resp, e.last});
               end
            end else begin
               r_hold = 1;
               held_data = bus.S_AXI_RDATA;
               held_ctl = {bus.S_AXI_RRESP, bus.S_AXI_RLAST};
            end
         end else begin
            r_hold = 0;
         end
         if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
            if (b_q.size() == 0) chk("b_unexpected", 1, 0);
            else chk("b_resp", bus.S_AXI_BRESP, b_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic do_write(input vec_t v);
      logic [3:0] idx;
      logic [31:0] d;
      int n;
      idx = v.addr[5:2];
      bus.S_AXI_AWADDR  = v.addr;
      bus.S_AXI_AWLEN   = v.len;
      bus.S_AXI_AWBURST = v.burst;
      bus.S_AXI_AWVALID = 1'b1;
      n = 0;
      @(negedge ACLK);
      while (!bus.S_AXI_AWREADY && n < 50) begin @(negedge ACLK); n++; end
      chk("aw_ready", bus.S_AXI_AWREADY, 1);
      tick();
      bus.S_AXI_AWVALID = 1'b0;
      for (int i = 0; i <= v.len; i++) begin
         d = v.base + i;
         bus.S_AXI_WDATA  = d;
         bus.S_AXI_WSTRB  = v.strb;
         bus.S_AXI_WLAST  = (v.early >= 0) ? (i == v.early) : (i == v.len);
         bus.S_AXI_WVALID = 1'b1;
         n = 0;
         @(negedge ACLK);
         while (!bus.S_AXI_WREADY && n < 50) begin @(negedge ACLK); n++; end
         chk("w_ready", bus.S_AXI_WREADY, 1);
         if (v.burst == INCR || v.burst == FIXED)
            for (int b = 0; b < 4; b++)
               if (v.strb[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
         if (v.burst == INCR) idx = idx + 4'd1;
         tick();
      end
      bus.S_AXI_WVALID = 1'b0;
      bus.S_AXI_WLAST  = 1'b0;
      chk("b_latency", {bus.S_AXI_WREADY, bus.S_AXI_BVALID}, 2'b01);
      b_q.push_back(v.resp);
      repeat (v.bdly) begin
         chk("b_hold", {bus.S_AXI_BVALID, bus.S_AXI_BRESP}, {1'b1, v.resp});
         tick();
      end
      bus.S_AXI_BREADY = 1'b1;
      n = 0;
      while (b_q.size() > 0 && n < 50) begin tick(); n++; end
      chk("b_timeout", b_q.size(), 0);
      b_q.delete();
      bus.S_AXI_BREADY = 1'b0;
      chk("b_done", {bus.S_AXI_BVALID, bus.S_AXI_AWREADY}, 2'b01);
   endtask

   task automatic do_read(input vec_t v);
      logic [3:0] idx;
      bit ok;
      int n;
      rexp_t e;
      idx = v.addr[5:2];
      ok = (v.burst == INCR || v.burst == FIXED);
      for (int i = 0; i <= v.len; i++) begin
         e.data = ok ? ref_mem[idx] : 32'h0;
         e.resp = v.resp;
         e.last = (i == v.len);
         r_q.push_back(e);
         if (v.burst == INCR) idx = idx + 4'd1;
      end
      bus.S_AXI_ARADDR  = v.addr;
      bus.S_AXI_ARLEN   = v.len;
      bus.S_AXI_ARBURST = v.burst;
      bus.S_AXI_ARVALID = 1'b1;
      n = 0;
      @(negedge ACLK);
      while (!bus.S_AXI_ARREADY && n < 50) begin @(negedge ACLK); n++; end
      chk("ar_ready", bus.S_AXI_ARREADY, 1);
      tick();
      bus.S_AXI_ARVALID = 1'b0;
      chk("r_first", {bus.S_AXI_RVALID, bus.S_AXI_ARREADY}, 2'b10);
      bus.S_AXI_RREADY = 1'b1;
      n = 0;
      while (r_q.size() > 0 && n < 200) begin
         tick();
         if (v.tog) bus.S_AXI_RREADY = ~bus.S_AXI_RREADY;
         n++;
      end
      chk("r_timeout", r_q.size(), 0);
      r_q.delete();
      bus.S_AXI_RREADY = 1'b0;
      chk("r_done", {bus.S_AXI_RVALID, bus.S_AXI_RLAST, bus.S_AXI_ARREADY},
          3'b001);
   endtask

   initial begin
      int n;
      rexp_t e;
      vec_t v;
      vecs[0]  = '{1, 8'h00, 8'd7, INCR,  32'd1,        4'hF, -1, 0, 0, OKAY};
      vecs[1]  = '{0, 8'h00, 8'd7, INCR,  32'd0,        4'hF, -1, 0, 0, OKAY};
      vecs[2]  = '{1, 8'h10, 8'd0, INCR,  32'h11223344, 4'hF, -1, 0, 0, OKAY};
      vecs[3]  = '{1, 8'h10, 8'd0, INCR,  32'hAABBCCDD, 4'h3, -1, 0, 0, OKAY};
      vecs[4]  = '{0, 8'h10, 8'd0, INCR,  32'd0,        4'hF, -1, 0, 0, OKAY};
      vecs[5]  = '{1, 8'h38, 8'd3, INCR,  32'h100,      4'hF, -1, 0, 0, OKAY};
      vecs[6]  = '{0, 8'h38, 8'd3, INCR,  32'd0,        4'hF, -1, 0, 0, OKAY};
      vecs[7]  = '{1, 8'h04, 8'd3, FIXED, 32'hA,        4'hF, -1, 0, 0, OKAY};
      vecs[8]  = '{0, 8'h04, 8'd0, INCR,  32'd0,        4'hF, -1, 0, 0, OKAY};
      vecs[9]  = '{1, 8'h00, 8'd7, INCR,  32'h50,       4'hF, -1, 5, 0, OKAY};
      vecs[10] = '{0, 8'h00, 8'd7, INCR,  32'd0,        4'hF, -1, 0, 1, OKAY};
      vecs[11] = '{1, 8'h00, 8'd3, WRAP,  32'h999,      4'hF, -1, 0, 0, SLVERR};
      vecs[12] = '{0, 8'h00, 8'd3, INCR,  32'd0,        4'hF, -1, 0, 0, OKAY};
      vecs[13] = '{0, 8'h00, 8'd3, RSVD,  32'd0,        4'hF, -1, 0, 0, SLVERR};
      vecs[14] = '{1, 8'h20, 8'd7, INCR,  32'h700,      4'hF,  2, 0, 0, SLVERR};
      vecs[15] = '{0, 8'h20, 8'd7, INCR,  32'd0,        4'hF, -1, 0, 0, OKAY};

      for (int i = 0; i < 16; i++) ref_mem[i] = 32'hx;
      ARESET = 1'b1;
      bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWBURST = '0;
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0;
      bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
      bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_ARBURST = '0;
      bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;

      repeat (3) tick();
      chk("rst_outs", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
          bus.S_AXI_BRESP, bus.S_AXI_ARREADY, bus.S_AXI_RVALID,
          bus.S_AXI_RLAST, bus.S_AXI_RRESP, bus.S_AXI_RDATA}, 0);
      ARESET = 1'b0;
      #2;
      chk("rst_rel_hold", {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}, 2'b00);
      tick();
      chk("rst_rel_ready", {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}, 2'b11);

      for (int i = 0; i < 16; i++) begin
         if (vecs[i].wr) do_write(vecs[i]);
         else do_read(vecs[i]);
      end

      // Reset while read beat 3 of 8 is on the bus.
      for (int i = 0; i < 8; i++) begin
         e.data = ref_mem[i];
         e.resp = OKAY;
         e.last = (i == 7);
         r_q.push_back(e);
      end
      bus.S_AXI_ARADDR = 8'h00; bus.S_AXI_ARLEN = 8'd7;
      bus.S_AXI_ARBURST = INCR; bus.S_AXI_ARVALID = 1'b1;
      tick();
      bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY = 1'b1;
      n = 0;
      while (r_q.size() > 6 && n < 50) begin tick(); n++; end
      chk("rst_setup", r_q.size(), 6);
      bus.S_AXI_RREADY = 1'b0;
      #2;
      ARESET = 1'b1;
      #1;
      chk("rst_async", {bus.S_AXI_RVALID, bus.S_AXI_RLAST,
          bus.S_AXI_ARREADY, bus.S_AXI_AWREADY}, 4'b0000);
      r_q.delete();
      @(posedge ACLK);
      #2;
      ARESET = 1'b0;
      tick();
      chk("rst_mid_ready", {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}, 2'b11);
      v = '{0, 8'h00, 8'd7, INCR, 32'd0, 4'hF, -1, 0, 0, OKAY};
      do_read(v);

      // Same-edge write and read of word 8: read returns the old value.
      bus.S_AXI_AWADDR = 8'h20; bus.S_AXI_AWLEN = 8'd0;
      bus.S_AXI_AWBURST = INCR; bus.S_AXI_AWVALID = 1'b1;
      tick();
      bus.S_AXI_AWVALID = 1'b0;
      e.data = ref_mem[8];
      e.resp = OKAY;
      e.last = 1'b1;
      r_q.push_back(e);
      b_q.push_back(OKAY);
      bus.S_AXI_WDATA = 32'hDEADBEEF; bus.S_AXI_WSTRB = 4'hF;
      bus.S_AXI_WLAST = 1'b1; bus.S_AXI_WVALID = 1'b1;
      bus.S_AXI_ARADDR = 8'h20; bus.S_AXI_ARLEN = 8'd0;
      bus.S_AXI_ARBURST = INCR; bus.S_AXI_ARVALID = 1'b1;
      chk("coinc_ready", {bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 2'b11);
      tick();
      bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0;
      bus.S_AXI_ARVALID = 1'b0;
      ref_mem[8] = 32'hDEADBEEF;
      bus.S_AXI_RREADY = 1'b1; bus.S_AXI_BREADY = 1'b1;
      n = 0;
      while ((r_q.size() > 0 || b_q.size() > 0) && n < 50) begin tick(); n++; end
      chk("coinc_timeout", r_q.size() + b_q.size(), 0);
      r_q.delete();
      b_q.delete();
      bus.S_AXI_RREADY = 1'b0; bus.S_AXI_BREADY = 1'b0;
      v = '{0, 8'h20, 8'd0, INCR, 32'd0, 4'hF, -1, 0, 0, OKAY};
      do_read(v);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
